osmanip_mem_arbiter: RTL

//  Two-port Avalon-MM arbiter in front of the 1024x32 single-port on-chip RAM (byteenable, 1-cycle read latency).

---
 rtl/osmanip_mem_pkg.sv | 18 +
 rtl/osmanip_rd_tag_pipe.sv | 34 +++
 rtl/osmanip_mem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/osmanip_mem_pkg.sv
// Shared definitions for the two-port on-chip RAM arbiter.
package osmanip_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    // Port identifiers as carried in grant history and read tags
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Which port, if any, currently holds the RAM under lock
    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_P0   = 2'd1,
        LK_P1   = 2'd2
    } lock_state_t;

endpackage

// File: rtl/osmanip_rd_tag_pipe.sv
// Read-return tag pipe: tracks which port issued each in-flight RAM read.
module osmanip_rd_tag_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_valid,
    input  logic in_port,
    output logic out_valid,
    output logic out_port
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] port_q;

    // Shift {valid, port} tags toward the output; reset discards in-flight reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            port_q <= '0;
        end else begin
            vld_q[0]  <= in_valid;
            port_q[0] <= in_port;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                port_q[i] <= port_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_port  = port_q[DEPTH-1];

endmodule

// File: rtl/osmanip_mem_arbiter.sv
// Two-port Avalon-MM arbiter for the single-port on-chip RAM.
// Port 0 is the HPS lightweight bridge, port 1 the local cube-state engine.
module osmanip_mem_arbiter
    import osmanip_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned MAX_LOCK   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   p0_address,
    input  logic [DATA_W/8-1:0] p0_byteenable,
    input  logic                p0_read,
    input  logic                p0_write,
    input  logic [DATA_W-1:0]   p0_writedata,
    input  logic                p0_lock,
    output logic                p0_waitrequest,
    output logic [DATA_W-1:0]   p0_readdata,
    output logic                p0_readdatavalid,
    input  logic [ADDR_W-1:0]   p1_address,
    input  logic [DATA_W/8-1:0] p1_byteenable,
    input  logic                p1_read,
    input  logic                p1_write,
    input  logic [DATA_W-1:0]   p1_writedata,
    input  logic                p1_lock,
    output logic                p1_waitrequest,
    output logic [DATA_W-1:0]   p1_readdata,
    output logic                p1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int unsigned      BE_W     = DATA_W / 8;
    localparam int unsigned      CNT_W    = $clog2(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              last_grant;
    lock_state_t       lock_state;
    logic [CNT_W-1:0]  lock_cnt;
    logic [CNT_W-1:0]  base_cnt;
    logic              acc_lock;
    logic              other_req;
    logic              force_release;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_issue;
    logic              tag_valid;
    logic              tag_port;

    assign req0 = p0_read | p0_write;
    assign req1 = p1_read | p1_write;

    // Grant: lock owner keeps the RAM while requesting, otherwise round-robin
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_state == LK_P0 && req0) begin
            gnt0 = 1'b1;
        end else if (lock_state == LK_P1 && req1) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            if (last_grant == PORT1) gnt0 = 1'b1;
            else                     gnt1 = 1'b1;
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

    assign p0_waitrequest = req0 & ~gnt0;
    assign p1_waitrequest = req1 & ~gnt1;

    // Lock run length seen by the granted port; a new owner starts counting from zero
    always_comb begin
        acc_lock  = gnt1 ? p1_lock : p0_lock;
        other_req = gnt1 ? req0 : req1;
        base_cnt  = '0;
        if ((gnt0 && lock_state == LK_P0) || (gnt1 && lock_state == LK_P1))
            base_cnt = lock_cnt;
        force_release = (base_cnt == CNT_LAST) && other_req;
    end

    // RAM-side mux; idle cycles replay the last issued fields
    always_comb begin
        mem_address    = addr_q;
        mem_byteenable = be_q;
        mem_writedata  = wdata_q;
        mem_write      = 1'b0;
        if (gnt0) begin
            mem_address    = p0_address;
            mem_byteenable = p0_byteenable;
            mem_writedata  = p0_writedata;
            mem_write      = p0_write;
        end else if (gnt1) begin
            mem_address    = p1_address;
            mem_byteenable = p1_byteenable;
            mem_writedata  = p1_writedata;
            mem_write      = p1_write;
        end
    end

    assign mem_chipselect = gnt0 | gnt1;
    assign mem_clken      = 1'b1;

    // Read+write together on one port performs only the write, so no tag is issued
    assign rd_issue = (gnt0 & p0_read & ~p0_write) | (gnt1 & p1_read & ~p1_write);

    // Grant history, lock owner/run counter and held RAM fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= PORT1;
            lock_state <= LK_NONE;
            lock_cnt   <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else if (gnt0 || gnt1) begin
            last_grant <= gnt1 ? PORT1 : PORT0;
            addr_q     <= mem_address;
            be_q       <= mem_byteenable;
            wdata_q    <= mem_writedata;
            if (acc_lock && !force_release) begin
                lock_state <= gnt1 ? LK_P1 : LK_P0;
                lock_cnt   <= (base_cnt == CNT_LAST) ? base_cnt : base_cnt + 1'b1;
            end else begin
                lock_state <= LK_NONE;
                lock_cnt   <= '0;
            end
        end else begin
            lock_state <= LK_NONE;
            lock_cnt   <= '0;
        end
    end

    osmanip_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_issue),
        .in_port   (gnt1),
        .out_valid (tag_valid),
        .out_port  (tag_port)
    );

    assign p0_readdatavalid = tag_valid & (tag_port == PORT0);
    assign p1_readdatavalid = tag_valid & (tag_port == PORT1);
    assign p0_readdata      = mem_readdata;
    assign p1_readdata      = mem_readdata;

endmodule
